// File: rtl/ip_hdr_arbiter.sv
// ip_hdr_arbiter: round-robin arbiter feeding a shared IP header builder.
// It keeps one transaction in flight and rejects requests shorter than MIN_LEN.
module ip_hdr_arbiter #(
  parameter int          NUM_REQ = 4,
  parameter int          TAG_W   = 2,
  parameter logic [15:0] MIN_LEN = 16'd20
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [32*NUM_REQ-1:0] req_src_ip,
  input  logic [32*NUM_REQ-1:0] req_dst_ip,
  input  logic [16*NUM_REQ-1:0] req_len,
  output logic                  bld_valid,
  input  logic                  bld_ready,
  output logic [31:0]           bld_src_ip,
  output logic [31:0]           bld_dst_ip,
  output logic [15:0]           bld_len,
  input  logic                  res_valid,
  output logic                  res_ready,
  input  logic [159:0]          res_header,
  output logic                  hdr_valid,
  input  logic                  hdr_ready,
  output logic [159:0]          hdr_data,
  output logic [TAG_W-1:0]      hdr_tag,
  output logic                  len_err,
  output logic [15:0]           err_cnt,
  output logic                  busy
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RES, DELIVER} state_t;
  state_t             state_q;
  logic [TAG_W-1:0]   rr_ptr_q, grant_q, grant_d;
  logic [TAG_W:0]     idx;
  logic               found;
  logic [31:0]        src_q, dst_q;
  logic [15:0]        len_q, err_cnt_q, grant_len;
  logic [159:0]       hdr_q;
  logic               len_err_q;
  function automatic logic [TAG_W-1:0] inc(input logic [TAG_W-1:0] t);
    return (t == TAG_W'(NUM_REQ-1)) ? '0 : t + 1'b1;
  endfunction
  // Walk downward so the candidate closest to rr_ptr is the last one written.
  always_comb begin
    grant_d = '0;
    found   = 1'b0;
    idx     = '0;
    for (int k = NUM_REQ-1; k >= 0; k--) begin
      idx = {1'b0, rr_ptr_q} + (TAG_W+1)'(k);
      idx = (idx >= (TAG_W+1)'(NUM_REQ)) ? idx - (TAG_W+1)'(NUM_REQ) : idx;
      if (req_valid[idx[TAG_W-1:0]]) begin
        grant_d = idx[TAG_W-1:0];
        found   = 1'b1;
      end
    end
  end
  assign grant_len  = req_len[16*grant_d +: 16];
  assign req_ready  = (rstn && state_q == IDLE && found) ? NUM_REQ'(1) << grant_d : '0;
  assign bld_valid  = state_q == ISSUE;
  assign res_ready  = state_q == WAIT_RES;
  assign hdr_valid  = state_q == DELIVER;
  assign busy       = state_q != IDLE;
  assign bld_src_ip = src_q;
  assign bld_dst_ip = dst_q;
  assign bld_len    = len_q;
  assign hdr_data   = hdr_q;
  assign hdr_tag    = grant_q;
  assign len_err    = len_err_q;
  assign err_cnt    = err_cnt_q;
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= IDLE;
      rr_ptr_q  <= '0;
      grant_q   <= '0;
      src_q     <= '0;
      dst_q     <= '0;
      len_q     <= '0;
      hdr_q     <= '0;
      len_err_q <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      len_err_q <= 1'b0;
      case (state_q)
        IDLE: if (found) begin
          grant_q <= grant_d;
          src_q   <= req_src_ip[32*grant_d +: 32];
          dst_q   <= req_dst_ip[32*grant_d +: 32];
          len_q   <= grant_len;
          if (grant_len >= MIN_LEN) state_q <= ISSUE;
          else begin
            len_err_q <= 1'b1;
            err_cnt_q <= (&err_cnt_q) ? err_cnt_q : err_cnt_q + 1'b1;
            rr_ptr_q  <= inc(grant_d);
          end
        end
        ISSUE: if (bld_ready) state_q <= WAIT_RES;
        WAIT_RES: if (res_valid) begin
          hdr_q   <= res_header;
          state_q <= DELIVER;
        end
        DELIVER: if (hdr_ready) begin
          state_q  <= IDLE;
          rr_ptr_q <= inc(grant_q);
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ip_hdr_arbiter.sv
// tb_ip_hdr_arbiter: transaction-level model compared every cycle, plus
// directed scenarios with literal expectations.
module tb_ip_hdr_arbiter;
  localparam int N = 4;
  logic           clk = 0, rstn = 0;
  logic [N-1:0]   req_valid = '0, req_ready;
  logic [32*N-1:0] req_src_ip = '0, req_dst_ip = '0;
  logic [16*N-1:0] req_len = '0;
  logic           bld_valid, bld_ready = 1;
  logic [31:0]    bld_src_ip, bld_dst_ip;
  logic [15:0]    bld_len;
  logic           res_valid = 1, res_ready;
  logic [159:0]   res_header = '0;
  logic           hdr_valid, hdr_ready = 1;
  logic [159:0]   hdr_data;
  logic [1:0]     hdr_tag;
  logic           len_err, busy;
  logic [15:0]    err_cnt;
  int checks = 0, failures = 0;

  ip_hdr_arbiter #(.NUM_REQ(N), .TAG_W(2), .MIN_LEN(16'd20)) dut (
    .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_ready(req_ready),
    .req_src_ip(req_src_ip), .req_dst_ip(req_dst_ip), .req_len(req_len),
    .bld_valid(bld_valid), .bld_ready(bld_ready), .bld_src_ip(bld_src_ip),
    .bld_dst_ip(bld_dst_ip), .bld_len(bld_len), .res_valid(res_valid),
    .res_ready(res_ready), .res_header(res_header), .hdr_valid(hdr_valid),
    .hdr_ready(hdr_ready), .hdr_data(hdr_data), .hdr_tag(hdr_tag),
    .len_err(len_err), .err_cnt(err_cnt), .busy(busy));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Phases: 0 waiting for a request, 1 builder request, 2 awaiting result, 3 delivering.
  int           m_phase, m_ptr, m_tag, m_g;
  logic [31:0]  m_src, m_dst;
  logic [15:0]  m_len, m_cnt;
  logic [159:0] m_hdr;
  logic         m_lerr;
  int           dq[$];

  function automatic int arb(input int p, input logic [N-1:0] v);
    for (int k = 0; k < N; k++) if (v[(p+k)%N]) return (p+k)%N;
    return -1;
  endfunction
  assign m_g = arb(m_ptr, req_valid);

  always @(posedge clk) begin
    if (!rstn) begin
      m_phase <= 0; m_ptr <= 0; m_tag <= 0; m_src <= '0; m_dst <= '0;
      m_len <= '0; m_cnt <= '0; m_hdr <= '0; m_lerr <= 1'b0;
    end else begin
      m_lerr <= 1'b0;
      if (m_phase == 0 && m_g >= 0) begin
        m_tag <= m_g;
        m_src <= req_src_ip[32*m_g +: 32];
        m_dst <= req_dst_ip[32*m_g +: 32];
        m_len <= req_len[16*m_g +: 16];
        if (req_len[16*m_g +: 16] >= 16'd20) m_phase <= 1;
        else begin
          m_lerr <= 1'b1;
          m_cnt  <= (m_cnt == 16'hFFFF) ? m_cnt : m_cnt + 16'd1;
          m_ptr  <= (m_g + 1) % N;
        end
      end
      if (m_phase == 1 && bld_ready) m_phase <= 2;
      if (m_phase == 2 && res_valid) begin m_hdr <= res_header; m_phase <= 3; end
      if (m_phase == 3 && hdr_ready) begin m_phase <= 0; m_ptr <= (m_tag + 1) % N; end
    end
  end

  always @(negedge clk) begin
    chk("req_ready", req_ready, (rstn && m_phase == 0 && m_g >= 0) ? 160'(1) << m_g : 160'(0));
    chk("busy", busy, m_phase != 0);
    chk("bld_valid", bld_valid, m_phase == 1);
    chk("res_ready", res_ready, m_phase == 2);
    chk("hdr_valid", hdr_valid, m_phase == 3);
    chk("bld_src", bld_src_ip, m_src);
    chk("bld_dst", bld_dst_ip, m_dst);
    chk("bld_len", bld_len, m_len);
    chk("hdr_data", hdr_data, m_hdr);
    chk("hdr_tag", hdr_tag, m_tag);
    chk("len_err", len_err, m_lerr);
    chk("err_cnt", err_cnt, m_cnt);
    if (hdr_valid && hdr_ready) dq.push_back(int'(hdr_tag));
  end

  task automatic set_req(input int i, input logic [31:0] s, input logic [31:0] d, input logic [15:0] l);
    req_src_ip[32*i +: 32] = s;
    req_dst_ip[32*i +: 32] = d;
    req_len[16*i +: 16]    = l;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  function automatic logic sel(input int w);
    return (w == 0) ? bld_valid : (w == 1) ? res_ready : hdr_valid;
  endfunction

  task automatic wait_sig(input int w, input string nm);
    int n = 0;
    do begin step(); n++; end while (!sel(w) && n < 60);
    chk(nm, sel(w), 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_a[5] = '{0, 1, 2, 3, 0};
    repeat (3) step();
    chk("rst_err_cnt", err_cnt, 16'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_hdr_data", hdr_data, 160'd0);
    chk("rst_bld_valid", bld_valid, 1'b0);
    rstn = 1;
    // All requesters active: rotation 0,1,2,3,0.
    for (int i = 0; i < N; i++) set_req(i, 32'hC0A80000 + i, 32'h0A0000F0 + i, 16'd40 + 16'(i));
    res_header = 160'h45000028_00000000_40060000_C0A80000_0A0000F0;
    req_valid = 4'hF;
    for (int n = 0; n < 100 && dq.size() < 5; n++) step();
    req_valid = '0;
    chk("a_count", dq.size(), 5);
    for (int k = 0; k < 5; k++) chk("a_order", (k < dq.size()) ? dq[k] : -1, exp_a[k]);
    // Single requester 2 with exact field values.
    set_req(2, 32'h0A000001, 32'h0A000002, 16'd60);
    res_header = 160'h4500003C_1234_4000_4006_0000_0A000001_0A000002;
    req_valid = 4'b0100;
    wait_sig(0, "b_bld_wait");
    req_valid = '0;
    chk("b_src", bld_src_ip, 32'h0A000001);
    chk("b_dst", bld_dst_ip, 32'h0A000002);
    chk("b_len", bld_len, 16'd60);
    wait_sig(2, "b_hdr_wait");
    chk("b_hdr", hdr_data, 160'h4500003C_1234_4000_4006_0000_0A000001_0A000002);
    chk("b_tag", hdr_tag, 2'd2);
    step();
    // Short request from requester 1 is rejected and the pointer moves to 2.
    set_req(1, 32'h01010101, 32'h02020202, 16'd19);
    req_valid = 4'b0010;
    step();
    req_valid = '0;
    chk("c_len_err", len_err, 1'b1);
    chk("c_err_cnt", err_cnt, 16'd1);
    chk("c_no_bld", bld_valid, 1'b0);
    step();
    chk("c_len_err_clear", len_err, 1'b0);
    set_req(1, 32'h01010101, 32'h02020202, 16'd40);
    req_valid = 4'hF;
    #1;
    chk("c_next_grant", req_ready, 4'b0100);
    wait_sig(0, "c_bld_wait");
    req_valid = '0;
    wait_sig(2, "c_hdr_wait");
    step();
    // Back-pressure on every handshake.
    bld_ready = 0; res_valid = 0; hdr_ready = 0;
    res_header = 160'hDEADBEEF_00000000_11111111_22222222_33333333;
    req_valid = 4'b0001;
    wait_sig(0, "d_bld_wait");
    req_valid = 4'hF;
    repeat (5) begin
      chk("d_ready_issue", req_ready, 4'b0000);
      chk("d_src_hold", bld_src_ip, 32'hC0A80000);
      step();
    end
    bld_ready = 1; step(); bld_ready = 0;
    repeat (3) begin
      chk("d_res_ready", res_ready, 1'b1);
      chk("d_ready_wait", req_ready, 4'b0000);
      step();
    end
    res_valid = 1; step(); res_valid = 0;
    repeat (4) begin
      chk("d_hdr_hold", hdr_data, 160'hDEADBEEF_00000000_11111111_22222222_33333333);
      chk("d_tag_hold", hdr_tag, 2'd0);
      chk("d_ready_dlv", req_ready, 4'b0000);
      step();
    end
    hdr_ready = 1; bld_ready = 1; res_valid = 1;
    repeat (20) step();
    req_valid = '0;
    repeat (10) step();
    // Reset while waiting for the builder result.
    res_valid = 0;
    req_valid = 4'b0001;
    wait_sig(1, "e_wait_res");
    req_valid = '0;
    rstn = 0;
    step();
    chk("e_busy", busy, 1'b0);
    chk("e_res_ready", res_ready, 1'b0);
    chk("e_bld_len", bld_len, 16'd0);
    chk("e_err_cnt", err_cnt, 16'd0);
    chk("e_hdr_data", hdr_data, 160'd0);
    rstn = 1; res_valid = 1;
    req_valid = 4'b1000;
    #1;
    chk("e_grant3", req_ready, 4'b1000);
    wait_sig(0, "e_bld_wait");
    req_valid = '0;
    wait_sig(2, "e_hdr_wait");
    chk("e_tag", hdr_tag, 2'd3);
    step();
    // Error counter saturation.
    set_req(0, 32'h0, 32'h0, 16'd5);
    req_valid = 4'b0001;
    repeat (65540) step();
    chk("f_err_sat", err_cnt, 16'hFFFF);
    chk("f_len_err_pulse", len_err, 1'b1);
    req_valid = '0;
    step();
    chk("f_len_err_clear", len_err, 1'b0);
    chk("f_err_hold", err_cnt, 16'hFFFF);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
